// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the multicycle sequencer and its datapath.
// The master modport is the controller side; the slave modport is the datapath side.
interface multicycle_control_unit_if;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    modport master (
        input  Op, funct3, funct7, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State
    );

    modport slave (
        output Op, funct3, funct7, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, State
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multicycle RV32I core: 11-state FSM plus ALU and
// immediate decoders driving every select and write enable of the datapath.
module multicycle_control_unit (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_unit_if.master  bus
);
    localparam int unsigned OP_W    = 7;
    localparam int unsigned STATE_W = 4;

    localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OP_W-1:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [STATE_W-1:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic       unused_funct7;

    always_ff @(posedge clk) begin
        if (!rst) state <= FETCH;
        else      state <= state_next;
    end

    // Next-state and per-state Moore outputs
    always_comb begin
        state_next = FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state)
            FETCH: begin
                state_next = DECODE;
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.Op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXECUTER;
                    OP_ITYPE:          state_next = EXECUTEI;
                    OP_JAL:            state_next = JAL;
                    OP_BEQ:            state_next = BEQ;
                    default:           state_next = FETCH;
                endcase
            end
            MEMADR: begin
                state_next = (bus.Op == OP_STORE) ? MEMWRITE : MEMREAD;
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
            end
            MEMREAD: begin
                state_next = MEMWB;
                adr_src    = 1'b1;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTER: begin
                state_next = ALUWB;
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
            end
            EXECUTEI: begin
                state_next = ALUWB;
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
            end
            ALUWB: begin
                reg_write = 1'b1;
            end
            JAL: begin
                state_next = ALUWB;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_update  = 1'b1;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            default: state_next = FETCH;
        endcase
    end

    // ALU operation decode; only sub for R-type (Op[5]) with funct7[5] set
    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  alu_control = (bus.Op[5] & bus.funct7[5]) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (bus.Op)
            OP_STORE: imm_src = 2'b01;
            OP_BEQ:   imm_src = 2'b10;
            OP_JAL:   imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

    // Write enables are held off for the whole reset cycle so no partial write escapes
    assign bus.PCWrite    = rst & (pc_update | (branch & bus.Zero));
    assign bus.IRWrite    = rst & ir_write;
    assign bus.RegWrite   = rst & reg_write;
    assign bus.MemWrite   = rst & mem_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUControl = alu_control;
    assign bus.State      = STATE_W'(state);

    assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style sequencing controller for the multicycle RV32I core. It replaces the single-cycle decoder pair with an 11-state FSM that steps the shared ALU, unified instruction/data memory and register file through fetch, decode, execute, memory and writeback cycles. It produces every mux select and write enable for the multicycle datapath from the opcode, the funct fields and the ALU `Zero` flag.

## Interface
- No parameters. Opcode set, state encoding and mux encodings are fixed below.
- clk  in  1  single clock. All state updates occur on the rising edge.
- rst  in  1  reset: synchronous, active-low.
- Op  in  7  opcode field of the instruction register.
- funct3  in  3  instruction bits [14:12].
- funct7  in  7  instruction bits [31:25].
- Zero  in  1  ALU zero flag, from the current-cycle ALU result.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write enable.
- IRWrite  out  1  enable for the instruction register and the OldPC register.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  Result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 (A register).
- ALUSrcB  out  2  ALU B select: 00 = rs2 (WriteData register), 01 = ImmExt, 10 = constant 4.
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- ALUControl  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- State  out  4  current FSM state, for debug and verification.

## Operation
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5
  - EXECUTER = 6, ALUWB = 7, EXECUTEI = 8, JAL = 9, BEQ = 10
  - Codes 11 to 15 are unreachable. If entered, the next state is FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEMADR when Op = 0000011 or 0100011.
  - DECODE -> EXECUTER when Op = 0110011.
  - DECODE -> EXECUTEI when Op = 0010011.
  - DECODE -> JAL when Op = 1101111.
  - DECODE -> BEQ when Op = 1100011.
  - DECODE -> FETCH for any other opcode. This is an illegal-instruction NOP with no writes.
  - MEMADR -> MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD -> MEMWB.
  - EXECUTER, EXECUTEI and JAL -> ALUWB.
  - MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- Per-state outputs. Any signal not listed is 0, and ALUOp defaults to 00.
  - FETCH: IRWrite = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ResultSrc = 10, PCUpdate = 1.
  - DECODE: ALUSrcA = 01, ALUSrcB = 01.
  - MEMADR: ALUSrcA = 10, ALUSrcB = 01.
  - MEMREAD: AdrSrc = 1.
  - MEMWB: ResultSrc = 01, RegWrite = 1.
  - MEMWRITE: AdrSrc = 1, MemWrite = 1.
  - EXECUTER: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10.
  - EXECUTEI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10.
  - ALUWB: ResultSrc = 00, RegWrite = 1.
  - JAL: ALUSrcA = 01, ALUSrcB = 10, PCUpdate = 1.
  - BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, Branch = 1.
- PCWrite = PCUpdate | (Branch & Zero).
- ALUControl is combinational from ALUOp, funct3, funct7[5] and Op[5]:
  - ALUOp 00 -> add. ALUOp 01 -> sub.
  - ALUOp 10 with funct3 000 -> sub if {Op[5], funct7[5]} = 11, otherwise add.
  - ALUOp 10 with funct3 010 -> slt, 110 -> or, 111 -> and.
  - Any other funct3 -> add.
- ImmSrc is combinational from Op:
  - 0000011 and 0010011 -> 00.
  - 0100011 -> 01.
  - 1100011 -> 10.
  - 1101111 -> 11.
  - Any other opcode -> 00.

## Timing
- Reset: when rst = 0 at a rising edge, State <= FETCH.
- While rst = 0, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 regardless of state.
- Reset asserted mid-instruction abandons the instruction. No partial write may occur in the reset cycle.
- The first cycle after rst returns to 1 is FETCH with IRWrite = 1.
- Output timing:
  - All outputs except PCWrite are functions of State, Op and funct only.
  - PCWrite additionally depends on same-cycle Zero, only in the BEQ state.
- Cycle counts, FETCH to FETCH:
  - lw 5.
  - sw, R-type, I-ALU and jal 4.
  - beq 3.
  - Illegal opcode 2.
- Op and funct are sampled from the instruction register, which is stable from DECODE until the next FETCH.
- Write enables are single-cycle pulses. Each instruction asserts RegWrite or MemWrite at most once.

## Test plan
- Reset mid-MEMREAD: drive rst = 0 for 1 edge -> State = 0 next cycle, all write enables 0 during reset, then a normal fetch.
- lw, Op = 0000011: State sequence 0, 1, 2, 3, 4, 0.
  - MEMADR: ALUControl = 000, ImmSrc = 00.
  - MEMREAD: AdrSrc = 1.
  - MEMWB: RegWrite = 1, ResultSrc = 01.
- sw, Op = 0100011: sequence 0, 1, 2, 5, 0. MemWrite = 1 in state 5 only, ImmSrc = 01, RegWrite never asserts.
- R-type sub then slt:
  - Op = 0110011, funct3 = 000, funct7 = 0100000 -> ALUControl = 001 in state 6.
  - funct3 = 010 -> ALUControl = 101.
  - addi with funct7[5] = 1 (Op = 0010011) -> ALUControl = 000.
- beq, Op = 1100011, ImmSrc = 10: sequence 0, 1, 10, 0.
  - Zero = 1 -> PCWrite = 1 in state 10.
  - Zero = 0 -> PCWrite = 0.
  - ALUControl = 001.
- jal, then illegal Op = 1111111:
  - jal: sequence 0, 1, 9, 7, 0 with PCWrite = 1 in 9, RegWrite = 1 in 7, ImmSrc = 11.
  - Illegal: sequence 0, 1, 0 with no write enables asserted.
